add128_slice_sequencer: RTL and testbench

//  Multi-cycle controller that computes a WIDTH-bit sum by reusing one SLICE-bit adder slice.

---
 rtl/add128_slice_sequencer_pkg.sv | 27 ++
 rtl/add128_slice_sequencer_if.sv | 25 ++
 rtl/add128_slice_add_slice_cin.sv | 13 +
 rtl/add128_slice_sequencer.sv | 104 ++++++++++
 tb/tb_add128_slice_sequencer.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/add128_slice_sequencer_pkg.sv
// Shared definitions for the slice-sequenced adder: state encoding and
// derivation of slice count, padded width and index width.
package add_seq_pkg;

    localparam int DEF_WIDTH = 128;
    localparam int DEF_SLICE = 7;

    // 2'd3 is not a legal state; the FSM falls back to ST_IDLE from it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int calc_nslice(input int w, input int s);
        return (w + s - 1) / s;
    endfunction

    function automatic int calc_padw(input int w, input int s);
        return calc_nslice(w, s) * s;
    endfunction

    function automatic int calc_idxw(input int w, input int s);
        return (calc_nslice(w, s) > 1) ? $clog2(calc_nslice(w, s)) : 1;
    endfunction

endpackage

// File: rtl/add128_slice_sequencer_if.sv
// Operand/result valid-ready bundle between producer, sequencer and consumer.
interface add128_slice_sequencer_if
    import add_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/add128_slice_add_slice_cin.sv
// Combinational SLICE-bit adder with carry in/out; the one shared adder
// resource that the sequencer reuses every cycle.
module add_slice_cin #(
    parameter int SLICE = 7
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co
);
    assign {co, s} = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, ci};
endmodule

// File: rtl/add128_slice_sequencer.sv
// WIDTH-bit adder computed LSB slice first over NSLICE cycles through one
// shared SLICE-bit adder, with valid/ready on operand and result sides.
module add128_slice_sequencer
    import add_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input logic                          clk,
    input logic                          rst,
    add128_slice_sequencer_if.slave      bus
);
    localparam int NSLICE = calc_nslice(WIDTH, SLICE);
    localparam int PADW   = calc_padw(WIDTH, SLICE);
    localparam int IDXW   = calc_idxw(WIDTH, SLICE);

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [PADW-1:0]   a_sh_q, a_sh_d;
    logic [PADW-1:0]   b_sh_q, b_sh_d;
    logic [PADW-1:0]   r_sh_q, r_sh_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic [SLICE-1:0]  slice_s;
    logic              slice_co;

    add_slice_cin #(.SLICE(SLICE)) u_slice (
        .x  (a_sh_q[SLICE-1:0]),
        .y  (b_sh_q[SLICE-1:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d  = PADW'(bus.a);
                    b_sh_d  = PADW'(bus.b);
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Result enters at the top so slice 0 lands at bit 0 after NSLICE shifts.
                r_sh_d  = {slice_s, r_sh_q[PADW-1:SLICE]};
                carry_d = slice_co;
                a_sh_d  = a_sh_q >> SLICE;
                b_sh_d  = b_sh_q >> SLICE;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == IDXW'(NSLICE - 1)) begin
                    sum_d   = r_sh_d[WIDTH-1:0];
                    cout_d  = r_sh_d[WIDTH];
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_add128_slice_sequencer.sv
// Directed and random checks of the slice-sequenced adder against a
// queue of golden 129-bit sums.
module tb_add128_slice_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    add128_slice_sequencer_if #(.WIDTH(128)) bus ();

    add128_slice_sequencer #(.WIDTH(128), .SLICE(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [128:0] sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [127:0] x, input logic [127:0] y);
        int n = 0;
        bus.a = x;
        bus.b = y;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        check("accept_ready", 129'(bus.in_ready), 129'(1));
        tick();
        sb.push_back({1'b0, x} + {1'b0, y});
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output bit rdy_seen);
        lat = 0;
        rdy_seen = 1'b0;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
            if (bus.in_ready) rdy_seen = 1'b1;
        end
        check("out_valid_rise", 129'(bus.out_valid), 129'(1));
    endtask

    task automatic take();
        logic [128:0] exp = '0;
        check("sb_depth", 129'(sb.size()), 129'(1));
        if (sb.size() > 0) exp = sb.pop_front();
        bus.out_ready = 1'b1;
        check("result", {bus.cout, bus.sum}, exp);
        tick();
        bus.out_ready = 1'b0;
        check("out_valid_drop", 129'(bus.out_valid), 129'(0));
        check("retain", {bus.cout, bus.sum}, exp);
    endtask

    task automatic recv(input int stall, output int lat, output bit rdy_seen);
        wait_valid(lat, rdy_seen);
        for (int i = 0; i < stall; i++) begin
            tick();
            if (bus.in_ready) rdy_seen = 1'b1;
        end
        take();
    endtask

    initial begin
        int lat;
        bit rdy;
        logic [128:0] held;
        logic [127:0] ra, rb;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 129'(bus.in_ready), 129'(1));
        check("rst_out_valid", 129'(bus.out_valid), 129'(0));
        check("rst_result", {bus.cout, bus.sum}, '0);

        // 1: zero operands, latency and in_ready during RUN/DONE
        send('0, '0);
        recv(2, lat, rdy);
        check("latency", 129'(lat), 129'(19));
        check("in_ready_busy", 129'(rdy), 129'(0));

        // 2: full ripple
        send('1, 128'd1);
        recv(0, lat, rdy);
        check("result_ripple", {bus.cout, bus.sum}, {1'b1, 128'd0});

        // 3: top-bit overflow, then slice0->slice1 carry
        send({1'b1, 127'd0}, {1'b1, 127'd0});
        recv(0, lat, rdy);
        send(128'h7F, 128'h01);
        recv(0, lat, rdy);
        check("result_7f", {bus.cout, bus.sum}, 129'h80);

        // 4: backpressure in DONE with in_valid toggling
        send(128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE, 128'hFFFF_0000_FFFF_0000_1111_2222_3333_4444);
        wait_valid(lat, rdy);
        held = sb[0];
        bus.a = 128'd1000;
        bus.b = 128'd2345;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.in_valid = ~bus.in_valid;
            check("stall_valid", 129'(bus.out_valid), 129'(1));
            check("stall_ready", 129'(bus.in_ready), 129'(0));
            check("stall_result", {bus.cout, bus.sum}, held);
        end
        bus.in_valid = 1'b1;
        take();
        check("idle_ready", 129'(bus.in_ready), 129'(1));
        tick();
        sb.push_back(129'd3345);
        bus.in_valid = 1'b0;
        check("accepted_next", 129'(bus.in_ready), 129'(0));
        recv(0, lat, rdy);
        check("latency_b2b", 129'(lat), 129'(19));

        // 5: reset mid-RUN at idx=10
        send(128'h1234_5678, 128'h8765_4321);
        for (int i = 0; i < 10; i++) tick();
        check("mid_run_busy", 129'(bus.in_ready), 129'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb.pop_front());
        check("mrst_in_ready", 129'(bus.in_ready), 129'(1));
        check("mrst_out_valid", 129'(bus.out_valid), 129'(0));
        check("mrst_result", {bus.cout, bus.sum}, '0);
        tick();
        check("mrst_no_emit", 129'(bus.out_valid), 129'(0));
        send(128'd5, 128'd9);
        recv(0, lat, rdy);
        check("result_14", {bus.cout, bus.sum}, 129'd14);

        // 6: random ops with random idle gaps and output stalls
        for (int n = 0; n < 1000; n++) begin
            ra = {$urandom(), $urandom(), $urandom(), $urandom()};
            rb = {$urandom(), $urandom(), $urandom(), $urandom()};
            case ($urandom_range(0, 7))
                0: ra = '1;
                1: rb = ~ra;
                2: rb = '0;
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) tick();
            end
            send(ra, rb);
            recv(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0, lat, rdy);
        end
        check("sb_drained", 129'(sb.size()), 129'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
